// File: rtl/opsg_pkg.sv
// rtl/opsg_pkg.sv - shared register map, constants and types for the OPSG register controller
package opsg_pkg;

  localparam int TONE_WIDTH_DEF  = 10;
  localparam int BUSY_CYCLES_DEF = 32;
  localparam int PRESCALE_DEF    = 16;

  localparam logic [2:0] REG_T0_FREQ  = 3'd0;
  localparam logic [2:0] REG_T0_ATTEN = 3'd1;
  localparam logic [2:0] REG_T1_FREQ  = 3'd2;
  localparam logic [2:0] REG_T1_ATTEN = 3'd3;
  localparam logic [2:0] REG_T2_FREQ  = 3'd4;
  localparam logic [2:0] REG_T2_ATTEN = 3'd5;
  localparam logic [2:0] REG_N_CTRL   = 3'd6;
  localparam logic [2:0] REG_N_ATTEN  = 3'd7;

  localparam int         LATCH_BIT = 7;
  localparam logic [3:0] ATTEN_OFF = 4'hF;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_BUSY
  } hs_state_t;

endpackage

// File: rtl/opsg_prescaler.sv
// rtl/opsg_prescaler.sv - free-running divider producing the shared tone clock enable
module opsg_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tone_en
);

  localparam int                CW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]     LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tone_en = (cnt_q == LAST);

endmodule

// File: rtl/opsg_reg_ctrl.sv
// rtl/opsg_reg_ctrl.sv - SN76489-style latch/data write handshake and register file
module opsg_reg_ctrl
  import opsg_pkg::*;
#(
  parameter int TONE_WIDTH  = TONE_WIDTH_DEF,
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF,
  parameter int PRESCALE    = PRESCALE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  output logic                  wr_ready,
  output logic                  tone_en,
  output logic [TONE_WIDTH-1:0] tone0_freq,
  output logic [TONE_WIDTH-1:0] tone1_freq,
  output logic [TONE_WIDTH-1:0] tone2_freq,
  output logic [3:0]            atten0,
  output logic [3:0]            atten1,
  output logic [3:0]            atten2,
  output logic [3:0]            atten3,
  output logic [2:0]            noise_ctrl,
  output logic                  noise_rst
);

  hs_state_t  state_q, state_d;
  logic [7:0] busy_cnt_q;
  logic       accept;
  logic       is_latch;
  logic [2:0] idx_q;
  logic [2:0] tgt;
  logic [9:0] tone_q [3];
  logic [3:0] atten_q [4];

  opsg_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .tone_en (tone_en)
  );

  // ST_INIT holds wr_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) state_d = ST_BUSY;
      end
      ST_BUSY: if (busy_cnt_q == 8'd0) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  assign accept = wr_valid & wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_q <= 8'd0;
    end else if (accept) begin
      busy_cnt_q <= 8'(BUSY_CYCLES - 1);
    end else if (state_q == ST_BUSY && busy_cnt_q != 8'd0) begin
      busy_cnt_q <= busy_cnt_q - 8'd1;
    end
  end

  // A latch byte addresses its own register; a data byte reuses the last latched index.
  assign is_latch = wr_data[LATCH_BIT];
  assign tgt      = is_latch ? wr_data[6:4] : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= REG_T0_FREQ;
      noise_ctrl <= 3'd0;
      noise_rst  <= 1'b0;
      for (int i = 0; i < 3; i++) tone_q[i] <= 10'd0;
      for (int i = 0; i < 4; i++) atten_q[i] <= ATTEN_OFF;
    end else begin
      noise_rst <= accept && (tgt == REG_N_CTRL);
      if (accept) begin
        if (is_latch) idx_q <= wr_data[6:4];
        case (tgt)
          REG_T0_FREQ, REG_T1_FREQ, REG_T2_FREQ: begin
            if (is_latch) tone_q[tgt[2:1]][3:0] <= wr_data[3:0];
            else          tone_q[tgt[2:1]][9:4] <= wr_data[5:0];
          end
          REG_N_CTRL: noise_ctrl <= wr_data[2:0];
          default:    atten_q[tgt[2:1]] <= wr_data[3:0];
        endcase
      end
    end
  end

  generate
    if (TONE_WIDTH > 10) begin : g_wide
      assign tone0_freq = {{(TONE_WIDTH-10){1'b0}}, tone_q[0]};
      assign tone1_freq = {{(TONE_WIDTH-10){1'b0}}, tone_q[1]};
      assign tone2_freq = {{(TONE_WIDTH-10){1'b0}}, tone_q[2]};
    end else begin : g_narrow
      assign tone0_freq = tone_q[0][TONE_WIDTH-1:0];
      assign tone1_freq = tone_q[1][TONE_WIDTH-1:0];
      assign tone2_freq = tone_q[2][TONE_WIDTH-1:0];
    end
  endgenerate

  assign atten0 = atten_q[0];
  assign atten1 = atten_q[1];
  assign atten2 = atten_q[2];
  assign atten3 = atten_q[3];

endmodule

// File: tb/tb_opsg_reg_ctrl.sv
// tb/tb_opsg_reg_ctrl.sv - directed self-checking bench for opsg_reg_ctrl
module tb_opsg_reg_ctrl;

  localparam int TW = 10;
  localparam int BC = 32;
  localparam int PS = 16;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          tone_en;
  logic [TW-1:0] tone0_freq, tone1_freq, tone2_freq;
  logic [3:0]    atten0, atten1, atten2, atten3;
  logic [2:0]    noise_ctrl;
  logic          noise_rst;

  int checks = 0;
  int errors = 0;

  opsg_reg_ctrl #(.TONE_WIDTH(TW), .BUSY_CYCLES(BC), .PRESCALE(PS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tone_en    (tone_en),
    .tone0_freq (tone0_freq),
    .tone1_freq (tone1_freq),
    .tone2_freq (tone2_freq),
    .atten0     (atten0),
    .atten1     (atten1),
    .atten2     (atten2),
    .atten3     (atten3),
    .noise_ctrl (noise_ctrl),
    .noise_rst  (noise_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic exp_nrst);
    int n;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = b;
    n = 0;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 200), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("nrst_pulse", 32'(noise_rst), 32'(exp_nrst));
    n = 0;
    while (!wr_ready && n < 100) begin
      n++;
      @(negedge clk);
      if (n == 1) chk("nrst_end", 32'(noise_rst), 32'd0);
    end
    chk("busy_len", 32'(n), 32'(BC));
  endtask

  initial begin
    int pulses, last, n;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_t0", 32'(tone0_freq), 32'h0);
    chk("rst_a3", 32'(atten3), 32'hF);
    chk("rst_nc", 32'(noise_ctrl), 32'h0);
    chk("rst_rdy", 32'(wr_ready), 32'h0);
    chk("rst_ten", 32'(tone_en), 32'h0);

    // Prescaler cadence from reset release, plus first-cycle ready.
    rst_n = 1'b1;
    #1 chk("rdy_release", 32'(wr_ready), 32'h0);
    pulses = 0;
    last   = -1;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k == 1) chk("rdy_first", 32'(wr_ready), 32'h1);
      if (tone_en) begin
        pulses++;
        if (last >= 0) chk("ten_period", 32'(k - last), 32'(PS));
        last = k;
      end
    end
    chk("ten_count", 32'(pulses), 32'd10);

    // Tone0 latch then data.
    send(8'h8E, 1'b0);
    chk("t0_lo", 32'(tone0_freq), 32'h00E);
    send(8'h0F, 1'b0);
    chk("t0_full", 32'(tone0_freq), 32'h0FE);

    // Attenuation latch and data.
    send(8'h9A, 1'b0);
    chk("a0_latch", 32'(atten0), 32'hA);
    send(8'h03, 1'b0);
    chk("a0_data", 32'(atten0), 32'h3);
    chk("t0_kept", 32'(tone0_freq), 32'h0FE);

    // Noise control pulses, noise atten does not.
    send(8'hE5, 1'b1);
    chk("nctrl", 32'(noise_ctrl), 32'h5);
    send(8'hF0, 1'b0);
    chk("a3", 32'(atten3), 32'h0);
    chk("nctrl_kept", 32'(noise_ctrl), 32'h5);

    // Byte held during BUSY must be ignored.
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 8'hA4;
    @(negedge clk);
    wr_data = 8'h3F;
    repeat (20) @(negedge clk);
    chk("busy_ign_t1", 32'(tone1_freq), 32'h004);
    wr_valid = 1'b0;
    n = 0;
    while (!wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_ign_to", 32'(n < 100), 32'd1);
    chk("busy_ign_t1b", 32'(tone1_freq), 32'h004);
    send(8'h3F, 1'b0);
    chk("t1_full", 32'(tone1_freq), 32'h3F4);
    chk("t2_zero", 32'(tone2_freq), 32'h000);

    // Reset in the middle of BUSY.
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 8'hC7;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("t2_lo", 32'(tone2_freq), 32'h007);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_t0", 32'(tone0_freq), 32'h0);
    chk("mid_t2", 32'(tone2_freq), 32'h0);
    chk("mid_a0", 32'(atten0), 32'hF);
    chk("mid_a3", 32'(atten3), 32'hF);
    chk("mid_nc", 32'(noise_ctrl), 32'h0);
    chk("mid_rdy", 32'(wr_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rdy_rel", 32'(wr_ready), 32'h0);
    @(negedge clk);
    chk("mid_rdy_next", 32'(wr_ready), 32'h1);

    // Data byte after reset lands in tone0 high bits.
    send(8'h05, 1'b0);
    chk("idx_reset", 32'(tone0_freq), 32'h050);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
